alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Integer ALU reservation/issue queue sitting directly downstream of the front-end dispatch cluster.
- Captures dispatched ALU instructions (queue_alu_en write strobe) with operand data or tags, snoops the CDB to resolve pending operands, and issues the oldest fully-ready entry to the ALU under a request/grant handshake with the issue unit.
- Back-pressures dispatch through a full flag.

Parameters:
- DEPTH, 4, number of queue entries (2..8); entries are kept in age order, with entry 0 the oldest.
- TAG_W, 6, width of ROB/rename tags.
- DATA_W, 32, operand data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- queue_alu_en  in  1  dispatch write strobe
- queue_op1_data  in  DATA_W  operand 1 value
- queue_op1_tag  in  TAG_W  operand 1 producer tag
- queue_op1_data_valid  in  1  operand 1 value present
- queue_op2_data  in  DATA_W  operand 2 value
- queue_op2_tag  in  TAG_W  operand 2 producer tag
- queue_op2_data_valid  in  1  operand 2 value present
- queue_rd_tag  in  TAG_W  destination tag
- queue_funct3  in  3  ALU funct3
- queue_alu_ext  in  3  ALU extension/opcode qualifier
- queue_full  out  1  no free entry; dispatch must not write
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB result tag
- cdb_data  in  DATA_W  CDB result value
- issue_req  out  1  at least one entry is ready
- issue_grant  in  1  issue unit accepts the presented entry this cycle
- issue_op1  out  DATA_W  selected entry operand 1
- issue_op2  out  DATA_W  selected entry operand 2
- issue_rd_tag  out  TAG_W  selected entry destination tag
- issue_funct3  out  3  selected entry funct3
- issue_ext  out  3  selected entry ext

Behaviour:
- Reset: all entry valid bits = 0, count = 0; queue_full = 0, issue_req = 0; issue_* data outputs = 0.
- Entry fields: valid, op1/op2 data, op1/op2 tag, op1/op2 ready, rd_tag, funct3, ext.
- queue_full = (count == DEPTH), derived from registered state only. No write-through when full, even if a grant occurs in the same cycle.

Write (dispatch):
- Accepted when queue_alu_en && !queue_full.
- The new entry is placed at the first free position after compaction, so it is always youngest.
- A write while full is ignored, with no state change.

Same-cycle CDB capture on write:
- If opN_data_valid = 0, cdb_valid = 1 and cdb_tag == opN_tag, the entry stores cdb_data with readyN = 1.
- Otherwise the entry stores the supplied data/tag; readyN = opN_data_valid.

CDB snoop:
- Every valid entry with readyN = 0 and matching cdb_tag captures cdb_data and sets readyN at the clock edge.
- Both operands may capture in the same cycle.
- An entry made ready this way becomes issue-eligible the next cycle. There is no combinational CDB-to-issue path.

Ready and select:
- An entry is ready when valid && ready1 && ready2.
- The selected entry is the lowest-index (oldest) ready entry, chosen by a combinational priority encoder.
- issue_req = any ready. issue_* outputs are combinational from the selected entry and are 0 when issue_req = 0.

Grant:
- issue_grant && issue_req removes the selected entry at the clock edge.
- Younger entries shift down one position, preserving age order; count decrements.
- issue_grant while issue_req = 0 is ignored.

Simultaneous write + grant (not full):
- Removal and compaction are applied first, then the new entry lands at index (count-1).
- Net count is unchanged.

Simultaneous CDB + grant:
- Shifted entries keep the CDB captures of that cycle; a broadcast is never lost during compaction.

Counting:
- count width is clog2(DEPTH+1); it never exceeds DEPTH or underflows.
- rst asserted mid-operation flushes all entries in one cycle regardless of other inputs.

Test Plan:
1. Reset, then write op1=5 (valid), op2=7 (valid), rd_tag=3 -> next cycle issue_req=1, issue_op1=5, issue_op2=7, issue_rd_tag=3. Grant -> following cycle issue_req=0, count=0.
2. Write an entry with op1 tag=9 not valid. CDB tag=9 data=0xDEAD two cycles later -> issue_req rises exactly one cycle after the broadcast, issue_op1=0xDEAD. A CDB with tag=8 causes no change.
3. Write an entry with op2 tag=4 not valid in the same cycle as CDB tag=4 data=0x11 -> the entry is ready on the next cycle with op2=0x11.
4. Fill with 4 entries (rd_tag 1..4), all ready -> queue_full=1. A 5th write is ignored. Grants issue rd_tag 1,2,3,4 in order; queue_full drops after the first grant.
5. Three entries with only entry 2 ready -> issue_rd_tag shows entry 2. Grant, then CDB makes entry 0 ready -> entry 0 is issued before the younger entries.
6. Queue with 2 entries: write + grant in one cycle -> count stays 2 and the new entry is youngest. Assert rst mid-stream -> next cycle count=0, queue_full=0, issue_req=0.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Integer ALU issue queue: age-ordered entries with CDB operand snooping,
// oldest-ready selection and compaction on grant.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              queue_alu_en,
    input  logic [DATA_W-1:0] queue_op1_data,
    input  logic [TAG_W-1:0]  queue_op1_tag,
    input  logic              queue_op1_data_valid,
    input  logic [DATA_W-1:0] queue_op2_data,
    input  logic [TAG_W-1:0]  queue_op2_tag,
    input  logic              queue_op2_data_valid,
    input  logic [TAG_W-1:0]  queue_rd_tag,
    input  logic [2:0]        queue_funct3,
    input  logic [2:0]        queue_alu_ext,
    output logic              queue_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_req,
    input  logic              issue_grant,
    output logic [DATA_W-1:0] issue_op1,
    output logic [DATA_W-1:0] issue_op2,
    output logic [TAG_W-1:0]  issue_rd_tag,
    output logic [2:0]        issue_funct3,
    output logic [2:0]        issue_ext
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic              rdy1;
        logic              rdy2;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [TAG_W-1:0]  rd;
        logic [2:0]        f3;
        logic [2:0]        ext;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           snp   [DEPTH];
    entry_t           ent_n [DEPTH];
    entry_t           new_ent;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;
    logic             any_ready;
    logic             grant_fire;
    logic             wr_fire;
    int               sel;
    int               wr_pos;

    assign queue_full = (count_q == CNT_W'(DEPTH));
    assign wr_fire    = queue_alu_en && !queue_full;
    assign grant_fire = issue_grant && any_ready;
    assign issue_req  = any_ready;

    // Each stored entry as it will look after this cycle's CDB broadcast.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp[i] = ent_q[i];
            if (ent_q[i].valid && cdb_valid) begin
                if (!ent_q[i].rdy1 && ent_q[i].tag1 == cdb_tag) begin
                    snp[i].op1  = cdb_data;
                    snp[i].rdy1 = 1'b1;
                end
                if (!ent_q[i].rdy2 && ent_q[i].tag2 == cdb_tag) begin
                    snp[i].op2  = cdb_data;
                    snp[i].rdy2 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.tag1  = queue_op1_tag;
        new_ent.tag2  = queue_op2_tag;
        new_ent.rd    = queue_rd_tag;
        new_ent.f3    = queue_funct3;
        new_ent.ext   = queue_alu_ext;
        if (!queue_op1_data_valid && cdb_valid && cdb_tag == queue_op1_tag) begin
            new_ent.op1  = cdb_data;
            new_ent.rdy1 = 1'b1;
        end else begin
            new_ent.op1  = queue_op1_data;
            new_ent.rdy1 = queue_op1_data_valid;
        end
        if (!queue_op2_data_valid && cdb_valid && cdb_tag == queue_op2_tag) begin
            new_ent.op2  = cdb_data;
            new_ent.rdy2 = 1'b1;
        end else begin
            new_ent.op2  = queue_op2_data;
            new_ent.rdy2 = queue_op2_data_valid;
        end
    end

    // Scan youngest to oldest so the last hit is the oldest ready entry.
    always_comb begin
        any_ready    = 1'b0;
        sel          = 0;
        issue_op1    = '0;
        issue_op2    = '0;
        issue_rd_tag = '0;
        issue_funct3 = '0;
        issue_ext    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                any_ready    = 1'b1;
                sel          = i;
                issue_op1    = ent_q[i].op1;
                issue_op2    = ent_q[i].op2;
                issue_rd_tag = ent_q[i].rd;
                issue_funct3 = ent_q[i].f3;
                issue_ext    = ent_q[i].ext;
            end
        end
    end

    // Compaction shifts the snooped copies, so captures survive the move.
    always_comb begin
        wr_pos = int'(count_q) - (grant_fire ? 1 : 0);
        for (int i = 0; i < DEPTH; i++) begin
            ent_n[i] = snp[i];
        end
        if (grant_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= sel) begin
                    ent_n[i] = snp[i + 1];
                end
            end
            ent_n[DEPTH-1].valid = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_fire && i == wr_pos) begin
                ent_n[i] = new_ent;
            end
        end
        count_n = count_q;
        if (wr_fire && !grant_fire) begin
            count_n = count_q + CNT_W'(1);
        end else if (!wr_fire && grant_fire) begin
            count_n = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
            end
        end else begin
            count_q <= count_n;
            ent_q   <= ent_n;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: dispatch, CDB capture, oldest-first
// issue, full handling, compaction and mid-stream reset.
module tb_alu_issue_queue;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              queue_alu_en;
    logic [DATA_W-1:0] queue_op1_data;
    logic [TAG_W-1:0]  queue_op1_tag;
    logic              queue_op1_data_valid;
    logic [DATA_W-1:0] queue_op2_data;
    logic [TAG_W-1:0]  queue_op2_tag;
    logic              queue_op2_data_valid;
    logic [TAG_W-1:0]  queue_rd_tag;
    logic [2:0]        queue_funct3;
    logic [2:0]        queue_alu_ext;
    logic              queue_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_req;
    logic              issue_grant;
    logic [DATA_W-1:0] issue_op1;
    logic [DATA_W-1:0] issue_op2;
    logic [TAG_W-1:0]  issue_rd_tag;
    logic [2:0]        issue_funct3;
    logic [2:0]        issue_ext;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .queue_alu_en(queue_alu_en),
        .queue_op1_data(queue_op1_data), .queue_op1_tag(queue_op1_tag),
        .queue_op1_data_valid(queue_op1_data_valid),
        .queue_op2_data(queue_op2_data), .queue_op2_tag(queue_op2_tag),
        .queue_op2_data_valid(queue_op2_data_valid),
        .queue_rd_tag(queue_rd_tag), .queue_funct3(queue_funct3),
        .queue_alu_ext(queue_alu_ext), .queue_full(queue_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_req(issue_req), .issue_grant(issue_grant),
        .issue_op1(issue_op1), .issue_op2(issue_op2),
        .issue_rd_tag(issue_rd_tag), .issue_funct3(issue_funct3),
        .issue_ext(issue_ext)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        queue_alu_en         = 1'b0;
        queue_op1_data       = '0;
        queue_op1_tag        = '0;
        queue_op1_data_valid = 1'b0;
        queue_op2_data       = '0;
        queue_op2_tag        = '0;
        queue_op2_data_valid = 1'b0;
        queue_rd_tag         = '0;
        queue_funct3         = '0;
        queue_alu_ext        = '0;
        cdb_valid            = 1'b0;
        cdb_tag              = '0;
        cdb_data             = '0;
        issue_grant          = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d1, input logic v1, input int t1,
                      input logic [31:0] d2, input logic v2, input int t2, input int rd);
        queue_alu_en         = 1'b1;
        queue_op1_data       = d1;
        queue_op1_data_valid = v1;
        queue_op1_tag        = TAG_W'(t1);
        queue_op2_data       = d2;
        queue_op2_data_valid = v2;
        queue_op2_tag        = TAG_W'(t2);
        queue_rd_tag         = TAG_W'(rd);
        queue_funct3         = 3'(rd);
        queue_alu_ext        = 3'(rd + 1);
    endtask

    task automatic cdb(input int t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = TAG_W'(t);
        cdb_data  = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_full", queue_full, 0);
        check("rst_req", issue_req, 0);
        check("rst_op1", issue_op1, 0);
        check("rst_rd", issue_rd_tag, 0);

        // 1: simple write, issue, grant
        wr(5, 1, 0, 7, 1, 0, 3);
        cyc();
        idle();
        check("t1_req", issue_req, 1);
        check("t1_op1", issue_op1, 5);
        check("t1_op2", issue_op2, 7);
        check("t1_rd", issue_rd_tag, 3);
        check("t1_f3", issue_funct3, 3);
        check("t1_ext", issue_ext, 4);
        issue_grant = 1'b1;
        cyc();
        idle();
        check("t1_req_after_grant", issue_req, 0);
        check("t1_full_after_grant", queue_full, 0);

        // 2: pending op1 woken by CDB two cycles later; unrelated tag ignored
        wr(0, 0, 9, 2, 1, 0, 10);
        cyc();
        idle();
        check("t2_req_pending", issue_req, 0);
        cdb(8, 32'h55);
        cyc();
        idle();
        check("t2_req_wrong_tag", issue_req, 0);
        cdb(9, 32'hDEAD);
        #1;
        check("t2_no_comb_path", issue_req, 0);
        cyc();
        idle();
        check("t2_req", issue_req, 1);
        check("t2_op1", issue_op1, 32'hDEAD);
        check("t2_op2", issue_op2, 2);
        check("t2_rd", issue_rd_tag, 10);
        issue_grant = 1'b1;
        cyc();
        idle();

        // 3: same-cycle CDB capture during dispatch
        wr(1, 1, 0, 0, 0, 4, 11);
        cdb(4, 32'h11);
        cyc();
        idle();
        check("t3_req", issue_req, 1);
        check("t3_op2", issue_op2, 32'h11);
        check("t3_rd", issue_rd_tag, 11);
        issue_grant = 1'b1;
        cyc();
        idle();
        check("t3_empty", issue_req, 0);

        // 4: fill, ignored write while full, in-order drain
        for (int k = 1; k <= 4; k++) begin
            wr(32'(k * 10), 1, 0, 32'(k), 1, 0, k);
            cyc();
        end
        idle();
        check("t4_full", queue_full, 1);
        wr(99, 1, 0, 99, 1, 0, 5);
        issue_grant = 1'b0;
        cyc();
        idle();
        check("t4_full_hold", queue_full, 1);
        for (int k = 1; k <= 4; k++) begin
            check("t4_order_rd", issue_rd_tag, 32'(k));
            check("t4_order_op1", issue_op1, 32'(k * 10));
            issue_grant = 1'b1;
            cyc();
            idle();
            if (k == 1) check("t4_full_drop", queue_full, 0);
        end
        check("t4_drained", issue_req, 0);

        // 5: younger ready entry bypasses, then oldest issues first
        wr(0, 0, 20, 1, 1, 0, 21);
        cyc();
        wr(0, 0, 22, 1, 1, 0, 22);
        cyc();
        wr(3, 1, 0, 4, 1, 0, 23);
        cyc();
        idle();
        check("t5_sel_young", issue_rd_tag, 23);
        issue_grant = 1'b1;
        cyc();
        idle();
        check("t5_none_ready", issue_req, 0);
        cdb(20, 32'h77);
        cyc();
        idle();
        check("t5_oldest_rd", issue_rd_tag, 21);
        check("t5_oldest_op1", issue_op1, 32'h77);
        // grant while CDB wakes the entry that is shifting down
        issue_grant = 1'b1;
        cdb(22, 32'h99);
        cyc();
        idle();
        check("t5_shift_req", issue_req, 1);
        check("t5_shift_rd", issue_rd_tag, 22);
        check("t5_shift_op1", issue_op1, 32'h99);
        issue_grant = 1'b1;
        cyc();
        idle();
        check("t5_empty", issue_req, 0);

        // 6: write + grant keeps count, then mid-stream reset
        wr(1, 1, 0, 1, 1, 0, 31);
        cyc();
        wr(2, 1, 0, 2, 1, 0, 32);
        cyc();
        wr(3, 1, 0, 3, 1, 0, 33);
        issue_grant = 1'b1;
        cyc();
        idle();
        check("t6_head", issue_rd_tag, 32);
        check("t6_not_full", queue_full, 0);
        wr(4, 1, 0, 4, 1, 0, 34);
        cyc();
        idle();
        check("t6_count3", queue_full, 0);
        wr(5, 1, 0, 5, 1, 0, 35);
        cyc();
        idle();
        check("t6_count4", queue_full, 1);
        issue_grant = 1'b1;
        cyc();
        idle();
        check("t6_young_order", issue_rd_tag, 33);
        rst = 1'b1;
        wr(6, 1, 0, 6, 1, 0, 36);
        issue_grant = 1'b1;
        cdb(1, 32'h1);
        cyc();
        rst = 1'b0;
        idle();
        check("t6_rst_full", queue_full, 0);
        check("t6_rst_req", issue_req, 0);
        check("t6_rst_op1", issue_op1, 0);
        wr(8, 1, 0, 9, 1, 0, 40);
        cyc();
        idle();
        check("t6_post_rst_rd", issue_rd_tag, 40);
        check("t6_post_rst_op2", issue_op2, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
